// File: rtl/audio_sample_conditioner.sv
// Stereo sample conditioner: per-channel volume scaling through one shared multiplier,
// an optional one-pole low-pass filter, and a registered output stage with overrun counting.
`timescale 1ns/1ps
module audio_sample_conditioner #(
  parameter int FILTER_SHIFT = 2
) (
  input  logic               clk_audio,
  input  logic               reset,
  input  logic               sample_valid,
  input  logic signed [15:0] in_l,
  input  logic signed [15:0] in_r,
  input  logic        [5:0]  volume,
  input  logic               filter_en,
  output logic signed [15:0] audio_l,
  output logic signed [15:0] audio_r,
  output logic               out_valid,
  output logic               busy,
  output logic        [7:0]  overrun_count
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SCALE_L = 3'd1,
    FILT_L  = 3'd2,
    SCALE_R = 3'd3,
    FILT_R  = 3'd4,
    COMMIT  = 3'd5
  } state_t;

  state_t r_state;
  state_t w_next;

  logic signed [15:0] r_in_l_p0;
  logic signed [15:0] r_in_r_p0;
  logic        [5:0]  r_vol_p0;
  logic               r_fen_p0;
  logic signed [15:0] r_s_p1;
  logic signed [15:0] r_acc_l;
  logic signed [15:0] r_acc_r;
  logic signed [15:0] r_audio_l;
  logic signed [15:0] r_audio_r;
  logic               r_out_valid;
  logic        [7:0]  r_overrun;

  logic               w_accept;
  logic signed [15:0] w_mul_x;
  logic signed [21:0] w_mul_x_ext;
  logic signed [21:0] w_vol_ext;
  logic signed [21:0] w_prod;
  logic signed [21:0] w_scaled;
  logic signed [15:0] w_acc_sel;
  logic signed [15:0] w_filt;

  // Clamp a scaled product into the 16-bit output range.
  function automatic logic signed [15:0] sat16(input logic signed [21:0] v);
    if (v > 22'sd32767)
      return 16'sh7FFF;
    else if (v < -22'sd32768)
      return 16'sh8000;
    else
      return v[15:0];
  endfunction

  // One-pole step; the result always lies between acc and s, so 16 bits suffice.
  function automatic logic signed [15:0] lp_step(input logic signed [15:0] acc,
                                                 input logic signed [15:0] s);
    logic signed [16:0] diff;
    diff = 17'(s) - 17'(acc);
    return 16'(17'(acc) + (diff >>> FILTER_SHIFT));
  endfunction

  assign w_accept = (r_state == IDLE) && sample_valid;

  always_ff @(posedge clk_audio or posedge reset) begin
    if (reset)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (sample_valid) w_next = SCALE_L;
      SCALE_L: w_next = FILT_L;
      FILT_L:  w_next = SCALE_R;
      SCALE_R: w_next = FILT_R;
      FILT_R:  w_next = COMMIT;
      COMMIT:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Stage p0: capture the sample and its controls for the whole pass
  always_ff @(posedge clk_audio) begin
    if (w_accept) begin
      r_in_l_p0 <= in_l;
      r_in_r_p0 <= in_r;
      r_vol_p0  <= volume;
      r_fen_p0  <= filter_en;
    end
  end

  assign w_mul_x     = (r_state == SCALE_R) ? r_in_r_p0 : r_in_l_p0;
  assign w_mul_x_ext = {{6{w_mul_x[15]}}, w_mul_x};
  assign w_vol_ext   = {16'd0, r_vol_p0};
  assign w_prod      = w_mul_x_ext * w_vol_ext;
  assign w_scaled    = w_prod >>> 4;

  // Stage p1: scaled and saturated sample for the channel in flight
  always_ff @(posedge clk_audio) begin
    if ((r_state == SCALE_L) || (r_state == SCALE_R))
      r_s_p1 <= sat16(w_scaled);
  end

  assign w_acc_sel = (r_state == FILT_R) ? r_acc_r : r_acc_l;
  assign w_filt    = lp_step(w_acc_sel, r_s_p1);

  // Stage p2: filter state; a bypassed pass still loads acc so re-enabling is seamless
  always_ff @(posedge clk_audio or posedge reset) begin
    if (reset) begin
      r_acc_l <= '0;
      r_acc_r <= '0;
    end else begin
      if (r_state == FILT_L)
        r_acc_l <= r_fen_p0 ? w_filt : r_s_p1;
      if (r_state == FILT_R)
        r_acc_r <= r_fen_p0 ? w_filt : r_s_p1;
    end
  end

  // Stage p3: publish both channels together
  always_ff @(posedge clk_audio or posedge reset) begin
    if (reset) begin
      r_audio_l   <= '0;
      r_audio_r   <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= (r_state == COMMIT);
      if (r_state == COMMIT) begin
        r_audio_l <= r_acc_l;
        r_audio_r <= r_acc_r;
      end
    end
  end

  always_ff @(posedge clk_audio or posedge reset) begin
    if (reset)
      r_overrun <= '0;
    else if (sample_valid && (r_state != IDLE) && (r_overrun != 8'hFF))
      r_overrun <= r_overrun + 8'd1;
  end

  assign audio_l       = r_audio_l;
  assign audio_r       = r_audio_r;
  assign out_valid     = r_out_valid;
  assign busy          = (r_state != IDLE);
  assign overrun_count = r_overrun;

endmodule

// File: doc/audio_sample_conditioner.md
AUDIO_SAMPLE_CONDITIONER -- requirements
Module: audio_sample_conditioner

Interface
REQ-001 SHALL have parameter FILTER_SHIFT, default 2, low-pass coefficient as right-shift amount, legal range 1..6.
REQ-002 SHALL have port clk_audio  input  1  sole clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port sample_valid  input  1  one-cycle strobe qualifying in_l/in_r.
REQ-005 SHALL have ports in_l, in_r  input  16 each  signed two's-complement core samples.
REQ-006 SHALL have port volume  input  6  unsigned gain; gain = volume/16, so 16 is unity and 63 is about 3.94x.
REQ-007 SHALL have port filter_en  input  1  enables the one-pole low-pass filter.
REQ-008 SHALL have ports audio_l, audio_r  output  16 each  signed conditioned samples, held between updates, consumed by the I2S stage.
REQ-009 SHALL have port out_valid  output  1  one-cycle pulse marking an audio_l/audio_r update.
REQ-010 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-011 SHALL have port overrun_count  output  8  saturating count of dropped samples.

Function
REQ-012 SHALL implement states IDLE, SCALE_L, FILT_L, SCALE_R, FILT_R, COMMIT, advancing one state per clock in that order, then COMMIT to IDLE.
REQ-013 SHALL, in IDLE with sample_valid=1 at edge N, capture in_l, in_r, volume and filter_en, and enter SCALE_L; the captured values are used for the whole pass.
REQ-014 SHALL, in SCALE_x, compute p = x * volume (22-bit signed), then s = p >>> 4 (arithmetic, rounds toward minus infinity), then saturate s to [-32768, 32767].
REQ-015 SHALL use one shared multiplier, time-multiplexed between left and right.
REQ-016 SHALL, in FILT_x with filter_en=1, update acc_x <= acc_x + ((s - acc_x) >>> FILTER_SHIFT), with the difference held at 17 bits signed and the result held in 16 bits.
REQ-017 SHALL, in FILT_x with filter_en=0, load acc_x <= s directly, so that enabling the filter later causes no step.
REQ-018 SHALL, in COMMIT, register audio_l <= acc_l and audio_r <= acc_r and pulse out_valid for exactly one cycle.
REQ-019 SHALL make the updated audio_l, audio_r and out_valid visible after edge N+5, giving a latency of 5 clocks.
REQ-020 SHALL make the earliest next accepted sample valid at edge N+6, giving a throughput of 1 sample per 6 clocks.
REQ-021 SHALL drop any sample_valid arriving while state is not IDLE (including COMMIT) and increment overrun_count.
REQ-022 SHALL hold overrun_count at 255 once reached; it SHALL clear only on reset.
REQ-023 SHALL leave any in-flight pass unaffected by a dropped sample.
REQ-024 SHALL apply changes to volume or filter_en that occur mid-pass starting from the next accepted sample only.
REQ-025 SHALL produce s = 0 for volume = 0; with filter_en=1 the output SHALL then decay toward 0 per REQ-016.

Reset
REQ-026 SHALL, while reset=1, force state=IDLE, audio_l=audio_r=0, out_valid=0, busy=0, overrun_count=0 and acc_l=acc_r=0, asynchronously.
REQ-027 SHALL, on reset asserted mid-pass, abort the pass with no out_valid pulse; the first sample after release SHALL be processed from acc=0.
REQ-028 SHALL ignore sample_valid during the reset-asserted cycle.

Verification
REQ-029 SHALL verify unity gain: volume=16, filter_en=0, in_l=0x1234, in_r=-100 at edge N -> audio_l=0x1234, audio_r=-100, out_valid high for exactly the one cycle after edge N+5.
REQ-030 SHALL verify saturation: volume=63, filter off, in_l=20000, in_r=-20000 -> audio_l=32767, audio_r=-32768; also in_l=-1, volume=1 -> audio_l=-1.
REQ-031 SHALL verify the filter step: FILTER_SHIFT=2, filter_en=1, volume=16, starting from acc=0, three samples in_l=16000 spaced 6 clocks apart -> audio_l sequence 4000, 7000, 9250.
REQ-032 SHALL verify overrun: sample_valid at edges N and N+2 -> a single out_valid, carrying the edge-N data, with overrun_count=1; 300 back-to-back strobes -> overrun_count=255.
REQ-033 SHALL verify reset mid-pass: reset asserted at edge N+3 of a pass -> no out_valid, audio_l=audio_r=0, busy=0 immediately.
REQ-034 SHALL verify filter hand-off: filter off with in_l=8000, then filter on with in_l=8000 -> audio_l remains 8000, with no transient.
